text_overlay: RTL and testbench

Parametrised text-window generator: a COLS x ROWS character buffer drawn at a fixed screen origin, with the font scaled by 2^SCALE_LOG2. Game logic writes the buffer at run time; there are no hard-coded strings. The block owns a writable character RAM, a clear state machine, a blink frame counter and a 3-stage pixel pipeline aligned to the synchronous font_rom. It sits beside the graphics generator, and the top-level RGB mux consumes its output.

---
 rtl/text_pkg.sv | 21 ++
 rtl/font_rom.sv | 43 ++++
 rtl/text_char_ram.sv | 32 +++
 rtl/text_overlay.sv | 215 +++++++++++++++++++++
 tb/tb_text_overlay.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/text_pkg.sv
// Shared definitions for the text overlay: character codes, attribute bit,
// controller states and a small window-range helper.
package text_pkg;

   localparam logic [6:0] CH_BLANK  = 7'h00;
   localparam logic [6:0] CH_SPACE  = 7'h20;
   localparam int         BLINK_BIT = 7;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   // Half-open range test on zero-extended 11-bit screen coordinates.
   function automatic logic in_range(input logic [10:0] v,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/font_rom.sv
// 8x16 glyph ROM with a registered output; address = {ascii[6:0], line[3:0]}.
// Bit 7 of each word is the leftmost pixel. Blank and space draw nothing,
// 'A' is a real glyph, and every other code draws its own code as a bar
// pattern so that distinct characters stay distinguishable on screen.
module font_rom
   import text_pkg::*;
(
   input  logic        clk,
   input  logic [10:0] addr_i,
   output logic [7:0]  data_o
);

   logic [7:0] glyph_s;
   logic [7:0] data_q;

   // Glyph lookup for the addressed character line.
   always_comb begin
      glyph_s = 8'h00;
      case (addr_i[10:4])
         CH_BLANK, CH_SPACE: glyph_s = 8'h00;
         7'h41: begin
            case (addr_i[3:0])
               4'h2:                      glyph_s = 8'h10;
               4'h3:                      glyph_s = 8'h38;
               4'h4:                      glyph_s = 8'h6C;
               4'h5, 4'h6:                glyph_s = 8'hC6;
               4'h7:                      glyph_s = 8'hFE;
               4'h8, 4'h9, 4'hA, 4'hB:    glyph_s = 8'hC6;
               default:                   glyph_s = 8'h00;
            endcase
         end
         default: glyph_s = {addr_i[10:4], 1'b1};
      endcase
   end

   // Synchronous ROM output register.
   always_ff @(posedge clk) begin
      data_q <= glyph_s;
   end

   assign data_o = data_q;

endmodule

// File: rtl/text_char_ram.sv
// Simple dual-port character RAM: one write port, one registered read port.
// A read of the address being written returns the previous contents.
module text_char_ram #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
)(
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];
   logic [7:0] rdata_q;

   // Write port.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read port (old data on a same-address collision).
   always_ff @(posedge clk) begin
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/text_overlay.sv
// Text window generator: writable character buffer, clear controller,
// blink frame counter and a 3-stage pixel pipeline around the font ROM.
module text_overlay
   import text_pkg::*;
#(
   parameter int         COLS       = 16,
   parameter int         ROWS       = 4,
   parameter int         SCALE_LOG2 = 0,
   parameter int         X0         = 256,
   parameter int         Y0         = 128,
   parameter logic [2:0] FG_RGB     = 3'b001,
   parameter logic [2:0] BG_RGB     = 3'b110,
   parameter int         BLINK_LOG2 = 5,
   localparam int        DEPTH      = COLS * ROWS,
   localparam int        AW         = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          reset_n,
   input  logic [9:0]    pix_x,
   input  logic [9:0]    pix_y,
   input  logic          frame_tick,
   input  logic          clr_req,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic          wr_mode,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_char,
   output logic          busy,
   output logic          text_on,
   output logic [2:0]    text_rgb
);

   localparam int              CW   = $clog2(COLS);
   localparam int              RW   = $clog2(ROWS);
   localparam logic [10:0]     X_LO = 11'(X0);
   localparam logic [10:0]     X_HI = 11'(X0 + ((COLS * 8) << SCALE_LOG2));
   localparam logic [10:0]     Y_LO = 11'(Y0);
   localparam logic [10:0]     Y_HI = 11'(Y0 + ((ROWS * 16) << SCALE_LOG2));
   localparam logic [AW-1:0]   LAST = AW'(DEPTH - 1);

   // Successor address in the buffer, wrapping after the last cell.
   function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
      return (a == LAST) ? {AW{1'b0}} : a + {{(AW-1){1'b0}}, 1'b1};
   endfunction

   // ---------------- control state ----------------
   state_e                state_q;
   logic [AW-1:0]         clr_addr_q;
   logic [AW-1:0]         cursor_q;
   logic                  busy_q;
   logic [BLINK_LOG2-1:0] frame_q;

   logic                  wr_fire_s;
   logic                  addr_ok_s;
   logic                  ram_we_s;
   logic [AW-1:0]         ram_waddr_s;
   logic [7:0]            ram_wdata_s;

   assign wr_ready  = (state_q == ST_IDLE) & ~clr_req;
   assign wr_fire_s = wr_valid & wr_ready;
   assign addr_ok_s = (32'(wr_addr) < 32'(DEPTH));
   assign busy      = busy_q;

   // RAM write port: the clear sweep owns it while clearing, else host writes.
   always_comb begin
      ram_we_s    = 1'b0;
      ram_waddr_s = clr_addr_q;
      ram_wdata_s = 8'h00;
      if (state_q == ST_CLEAR) begin
         ram_we_s = 1'b1;
      end else if (wr_fire_s) begin
         ram_we_s    = wr_mode | addr_ok_s;
         ram_waddr_s = wr_mode ? cursor_q : wr_addr;
         ram_wdata_s = wr_char;
      end else begin
         ram_we_s = 1'b0;
      end
   end

   // Clear controller and write cursor.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= {AW{1'b0}};
         cursor_q   <= {AW{1'b0}};
         busy_q     <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (clr_req) begin
                  state_q    <= ST_CLEAR;
                  clr_addr_q <= {AW{1'b0}};
                  cursor_q   <= {AW{1'b0}};
                  busy_q     <= 1'b1;
               end else if (wr_fire_s) begin
                  if (wr_mode) begin
                     cursor_q <= next_addr(cursor_q);
                  end else if (addr_ok_s) begin
                     cursor_q <= next_addr(wr_addr);
                  end
               end
            end
            ST_CLEAR: begin
               if (clr_addr_q == LAST) begin
                  state_q    <= ST_IDLE;
                  clr_addr_q <= {AW{1'b0}};
                  busy_q     <= 1'b0;
               end else begin
                  clr_addr_q <= clr_addr_q + {{(AW-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state_q    <= ST_CLEAR;
               clr_addr_q <= {AW{1'b0}};
               cursor_q   <= {AW{1'b0}};
               busy_q     <= 1'b1;
            end
         endcase
      end
   end

   // Free-running frame counter; its MSB is the blink phase.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_q <= {BLINK_LOG2{1'b0}};
      end else if (frame_tick) begin
         frame_q <= frame_q + {{(BLINK_LOG2-1){1'b0}}, 1'b1};
      end
   end

   // ---------------- pixel pipeline ----------------
   logic          hit_s;
   logic [CW-1:0] col_s;
   logic [RW-1:0] row_s;
   logic [2:0]    bit_s;
   logic [3:0]    line_s;
   logic [AW-1:0] raddr_s;
   logic [7:0]    ram_rdata_s;
   logic [7:0]    font_word_s;
   logic          font_bit_s;
   logic          pix_fg_s;
   logic [2:0]    rgb_d;

   logic          hit0_q, hit1_q;
   logic [3:0]    line0_q;
   logic [2:0]    bit0_q, bit1_q;
   logic          blink1_q;
   logic          text_on_q;
   logic [2:0]    text_rgb_q;

   assign hit_s   = in_range({1'b0, pix_x}, X_LO, X_HI) &
                    in_range({1'b0, pix_y}, Y_LO, Y_HI);
   assign col_s   = CW'((pix_x - 10'(X0)) >> (3 + SCALE_LOG2));
   assign row_s   = RW'((pix_y - 10'(Y0)) >> (4 + SCALE_LOG2));
   assign bit_s   = 3'((pix_x - 10'(X0)) >> SCALE_LOG2);
   assign line_s  = 4'((pix_y - 10'(Y0)) >> SCALE_LOG2);
   assign raddr_s = {row_s, col_s};

   text_char_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we_s),
      .waddr_i (ram_waddr_s),
      .wdata_i (ram_wdata_s),
      .raddr_i (raddr_s),
      .rdata_o (ram_rdata_s)
   );

   font_rom u_font (
      .clk    (clk),
      .addr_i ({ram_rdata_s[6:0], line0_q}),
      .data_o (font_word_s)
   );

   assign font_bit_s = font_word_s[~bit1_q];

   // Final colour decision; blinking glyphs vanish in the high blink phase.
   always_comb begin
      pix_fg_s = hit1_q & font_bit_s & ~(blink1_q & frame_q[BLINK_LOG2-1]);
      if (pix_fg_s) begin
         rgb_d = FG_RGB;
      end else begin
         rgb_d = BG_RGB;
      end
   end

   // Pipeline registers: S0 beside the RAM read, S1 beside the ROM, S2 outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit0_q     <= 1'b0;
         line0_q    <= 4'h0;
         bit0_q     <= 3'h0;
         hit1_q     <= 1'b0;
         bit1_q     <= 3'h0;
         blink1_q   <= 1'b0;
         text_on_q  <= 1'b0;
         text_rgb_q <= BG_RGB;
      end else begin
         hit0_q     <= hit_s;
         line0_q    <= line_s;
         bit0_q     <= bit_s;
         hit1_q     <= hit0_q;
         bit1_q     <= bit0_q;
         blink1_q   <= ram_rdata_s[BLINK_BIT];
         text_on_q  <= hit1_q;
         text_rgb_q <= rgb_d;
      end
   end

   assign text_on  = text_on_q;
   assign text_rgb = text_rgb_q;

endmodule

// File: tb/tb_text_overlay.sv
// Self-checking bench for text_overlay: a default build and a 2x-scaled
// build share all inputs; pixel results are scoreboarded with a 3-cycle lag.
module tb_text_overlay;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [9:0] pix_x, pix_y;
   logic       frame_tick, clr_req, wr_valid, wr_mode;
   logic [5:0] wr_addr;
   logic [7:0] wr_char;

   logic       wr_ready0, busy0, text_on0;
   logic [2:0] text_rgb0;
   logic       wr_ready1, busy1, text_on1;
   logic [2:0] text_rgb1;

   always #5 clk = ~clk;

   text_overlay u_dut0 (
      .clk(clk), .reset_n(reset_n), .pix_x(pix_x), .pix_y(pix_y),
      .frame_tick(frame_tick), .clr_req(clr_req), .wr_valid(wr_valid),
      .wr_ready(wr_ready0), .wr_mode(wr_mode), .wr_addr(wr_addr),
      .wr_char(wr_char), .busy(busy0), .text_on(text_on0), .text_rgb(text_rgb0)
   );

   text_overlay #(.SCALE_LOG2(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .pix_x(pix_x), .pix_y(pix_y),
      .frame_tick(frame_tick), .clr_req(clr_req), .wr_valid(wr_valid),
      .wr_ready(wr_ready1), .wr_mode(wr_mode), .wr_addr(wr_addr),
      .wr_char(wr_char), .busy(busy1), .text_on(text_on1), .text_rgb(text_rgb1)
   );

   typedef struct packed {
      logic       chk;
      logic [3:0] e0;
      logic [3:0] e1;
   } sb_t;

   sb_t        sbq[$];
   int         n_vec  = 0;
   int         n_miss = 0;
   logic [7:0] m_ram [64];
   int         m_cur;
   logic [4:0] m_frames;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] m_glyph(input logic [6:0] c, input int ln);
      if (c == 7'h00 || c == 7'h20) return 8'h00;
      if (c == 7'h41) begin
         case (ln)
            2:             return 8'h10;
            3:             return 8'h38;
            4:             return 8'h6C;
            5, 6:          return 8'hC6;
            7:             return 8'hFE;
            8, 9, 10, 11:  return 8'hC6;
            default:       return 8'h00;
         endcase
      end
      return {c, 1'b1};
   endfunction

   // Expected {text_on, text_rgb} for a pixel at scale s.
   function automatic logic [3:0] m_pix(input int x, input int y, input int s);
      int wx, wy, lx, ly, col, row, b, ln;
      logic [7:0] ch, g;
      wx = 128 << s;
      wy = 64 << s;
      if (x < 256 || x >= 256 + wx || y < 128 || y >= 128 + wy) return {1'b0, 3'b110};
      lx  = x - 256;
      ly  = y - 128;
      col = lx >> (3 + s);
      row = ly >> (4 + s);
      b   = (lx >> s) % 8;
      ln  = (ly >> s) % 16;
      ch  = m_ram[row * 16 + col];
      g   = m_glyph(ch[6:0], ln);
      if (g[7 - b] && !(ch[7] && m_frames[4])) return {1'b1, 3'b001};
      return {1'b1, 3'b110};
   endfunction

   // One pixel per cycle: compare the result due now, then drive and push.
   task automatic pix_cycle(input int x, input int y, input logic do_chk);
      sb_t e;
      @(negedge clk);
      if (sbq.size() == 3) begin
         e = sbq.pop_front();
         if (e.chk) begin
            chk("pix_s0", {28'h0, text_on0, text_rgb0}, {28'h0, e.e0});
            chk("pix_s1", {28'h0, text_on1, text_rgb1}, {28'h0, e.e1});
         end
      end
      pix_x = 10'(x);
      pix_y = 10'(y);
      e.chk = do_chk;
      e.e0  = m_pix(x, y, 0);
      e.e1  = m_pix(x, y, 1);
      sbq.push_back(e);
   endtask

   task automatic pix_flush();
      repeat (3) pix_cycle(0, 0, 1'b0);
      sbq.delete();
   endtask

   task automatic sweep(input int x0, input int x1, input int y0, input int y1);
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++)
            pix_cycle(x, y, 1'b1);
      pix_flush();
   endtask

   task automatic wr_a(input int a, input logic [7:0] c);
      @(negedge clk);
      wr_valid = 1'b1; wr_mode = 1'b0; wr_addr = 6'(a); wr_char = c;
      #1 chk("wr_ready_addr", {31'h0, wr_ready0}, 32'h1);
      @(posedge clk);
      #1 wr_valid = 1'b0;
      m_ram[a] = c;
      m_cur    = (a + 1) % 64;
   endtask

   task automatic wr_c(input logic [7:0] c);
      @(negedge clk);
      wr_valid = 1'b1; wr_mode = 1'b1; wr_char = c;
      @(posedge clk);
      #1 wr_valid = 1'b0;
      m_ram[m_cur] = c;
      m_cur        = (m_cur + 1) % 64;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk); frame_tick = 1'b1;
         @(negedge clk); frame_tick = 1'b0;
         m_frames = m_frames + 5'd1;
      end
   endtask

   // Called at a falling edge where busy is expected high; counts busy cycles.
   task automatic wait_clear(input string tag);
      int   n   = 0;
      logic rdy = 1'b0;
      while (busy0 && n < 200) begin
         if (wr_ready0) rdy = 1'b1;
         n++;
         @(negedge clk);
      end
      chk({tag, "_len"}, 32'(n), 32'd64);
      chk({tag, "_rdy"}, {31'h0, rdy}, 32'h0);
      chk({tag, "_busy1"}, {31'h0, busy1}, 32'h0);
      for (int i = 0; i < 64; i++) m_ram[i] = 8'h00;
      m_cur = 0;
   endtask

   initial begin
      reset_n = 1'b0; pix_x = 10'd0; pix_y = 10'd0; frame_tick = 1'b0;
      clr_req = 1'b0; wr_valid = 1'b0; wr_mode = 1'b0; wr_addr = 6'd0; wr_char = 8'h00;
      m_frames = 5'd0; m_cur = 0;
      for (int i = 0; i < 64; i++) m_ram[i] = 8'h00;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_busy",   {31'h0, busy0},     32'h1);
      chk("rst_ready",  {31'h0, wr_ready0}, 32'h0);
      chk("rst_on",     {31'h0, text_on0},  32'h0);
      chk("rst_rgb",    {29'h0, text_rgb0}, 32'h6);
      chk("rst_rgb_s1", {29'h0, text_rgb1}, 32'h6);
      reset_n = 1'b1;
      wait_clear("clr_boot");

      // blank window plus outside / blanking pixels
      for (int y = 128; y < 192; y += 7)
         for (int x = 256; x < 384; x += 9)
            pix_cycle(x, y, 1'b1);
      pix_cycle(255, 128, 1'b1);
      pix_cycle(800, 500, 1'b1);
      pix_cycle(1023, 1023, 1'b1);
      pix_cycle(256, 127, 1'b1);
      pix_flush();

      // glyph 'A' at cell 0, scale 1 covers 2x2 pixels per font bit
      wr_a(0, 8'h41);
      sweep(255, 271, 128, 159);

      // window edges for both builds
      pix_cycle(383, 128, 1'b1);
      pix_cycle(384, 128, 1'b1);
      pix_cycle(511, 128, 1'b1);
      pix_cycle(512, 128, 1'b1);
      pix_cycle(256, 191, 1'b1);
      pix_cycle(256, 192, 1'b1);
      pix_cycle(256, 255, 1'b1);
      pix_cycle(256, 256, 1'b1);
      pix_flush();

      // addressed write to the last cell wraps the cursor; 65 cursor writes
      wr_a(63, 8'h7E);
      for (int i = 0; i < 65; i++) wr_c(8'(8'h30 + i));
      sweep(256, 279, 128, 128);
      sweep(376, 383, 191, 191);

      // blinking 'A'
      wr_a(0, 8'hC1);
      sweep(256, 263, 131, 131);
      tick(16);
      sweep(256, 263, 131, 131);
      sweep(256, 263, 135, 135);
      tick(16);
      sweep(256, 263, 135, 135);

      // clear and write together: clear wins
      @(negedge clk);
      clr_req = 1'b1; wr_valid = 1'b1; wr_mode = 1'b0; wr_addr = 6'd5; wr_char = 8'h5A;
      #1 chk("collide_ready", {31'h0, wr_ready0}, 32'h0);
      @(posedge clk);
      #1 begin clr_req = 1'b0; wr_valid = 1'b0; end
      @(negedge clk);
      wait_clear("clr_req");
      sweep(256, 303, 128, 128);

      // reset in the middle of a clear restarts it from address 0
      wr_a(7, 8'h41);
      @(negedge clk); clr_req = 1'b1;
      @(negedge clk); clr_req = 1'b0;
      repeat (9) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", {31'h0, busy0}, 32'h1);
      reset_n  = 1'b1;
      m_frames = 5'd0;
      wait_clear("clr_abort");
      sweep(256, 327, 128, 131);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
